// File: rtl/dot_prod_acc_if.sv
// Streaming bus for dot_prod_acc: beat inputs with frame delimiters, one result per frame.
interface dot_prod_acc_if #(
   parameter int AW   = 9,
   parameter int BW   = 8,
   parameter int N    = 3,
   parameter int ACCW = 32
);
   logic                   in_valid;
   logic                   in_first;
   logic                   in_last;
   logic                   in_neg;
   logic [N*AW-1:0]        a;
   logic [N*BW-1:0]        b;
   logic                   out_valid;
   logic signed [ACCW-1:0] out_p;
   logic                   out_ovf;

   modport master (
      output in_valid, in_first, in_last, in_neg, a, b,
      input  out_valid, out_p, out_ovf
   );

   modport slave (
      input  in_valid, in_first, in_last, in_neg, a, b,
      output out_valid, out_p, out_ovf
   );
endinterface

// File: rtl/dot_prod_acc.sv
// N-element signed dot product with per-frame accumulation, 3-cycle latency.
// Define DOT_PROD_ACC_SAT_EN for a saturating accumulator with sticky overflow flag.
module dot_prod_acc #(
   parameter int AW   = 9,
   parameter int BW   = 8,
   parameter int N    = 3,
   parameter int ACCW = 32
) (
   input logic          clk,
   input logic          rst,
   dot_prod_acc_if.slave bus
);
   localparam int PW = AW + BW;
   localparam int SW = AW + BW + $clog2(N) + 1;

   generate
      if (ACCW < SW) begin : g_accw_check
         $error("dot_prod_acc: ACCW must be >= AW+BW+clog2(N)+1");
      end
   endgenerate

   function automatic logic signed [SW-1:0] ext_prod(input logic signed [AW-1:0] x,
                                                    input logic signed [BW-1:0] y);
      logic signed [PW-1:0] p;
      p = PW'(x) * PW'(y);
      return SW'(p);
   endfunction

`ifdef DOT_PROD_ACC_SAT_EN
   function automatic logic signed [ACCW-1:0] sat_clip(input logic signed [ACCW:0] x);
      if (x[ACCW] != x[ACCW-1])
         return x[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
      return x[ACCW-1:0];
   endfunction

   function automatic logic sat_hit(input logic signed [ACCW:0] x);
      return x[ACCW] != x[ACCW-1];
   endfunction
`endif

   // S1: register inputs
   logic signed [AW-1:0] a_p1 [N];
   logic signed [BW-1:0] b_p1 [N];
   logic                 vld_p1, first_p1, last_p1, neg_p1;

   always_ff @(posedge clk) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= bus.in_valid;
      first_p1 <= bus.in_first;
      last_p1  <= bus.in_last;
      neg_p1   <= bus.in_neg;
      for (int i = 0; i < N; i++) begin
         a_p1[i] <= bus.a[i*AW +: AW];
         b_p1[i] <= bus.b[i*BW +: BW];
      end
   end

   // S2: products summed at SW bits, optional negation
   logic signed [SW-1:0] beat_sum_c;
   logic signed [SW-1:0] beat_sum_p2;
   logic                 vld_p2, first_p2, last_p2;

   always_comb begin
      beat_sum_c = '0;
      for (int i = 0; i < N; i++)
         beat_sum_c = beat_sum_c + ext_prod(a_p1[i], b_p1[i]);
      if (neg_p1) beat_sum_c = -beat_sum_c;
   end

   always_ff @(posedge clk) begin
      if (rst) vld_p2 <= 1'b0;
      else     vld_p2 <= vld_p1;
      first_p2    <= first_p1;
      last_p2     <= last_p1;
      beat_sum_p2 <= beat_sum_c;
   end

   // S3: frame accumulator and result register
   logic signed [ACCW-1:0] acc_p3;
   logic signed [ACCW-1:0] acc_base;
   logic signed [ACCW-1:0] acc_next;
   logic signed [ACCW-1:0] out_p_p3;
   logic                   out_valid_p3;

   assign acc_base = first_p2 ? '0 : acc_p3;

`ifdef DOT_PROD_ACC_SAT_EN
   logic signed [ACCW:0] acc_wide;
   logic                 sat_now;
   logic                 sticky_p3, sticky_next, ovf_p3;

   always_comb begin
      acc_wide    = (ACCW+1)'(acc_base) + (ACCW+1)'(beat_sum_p2);
      acc_next    = sat_clip(acc_wide);
      sat_now     = sat_hit(acc_wide);
      sticky_next = (first_p2 ? 1'b0 : sticky_p3) | sat_now;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_p3 <= 1'b0;
         ovf_p3    <= 1'b0;
      end else if (vld_p2) begin
         sticky_p3 <= sticky_next;
         if (last_p2) ovf_p3 <= sticky_next;
      end
   end

   assign bus.out_ovf = ovf_p3;
`else
   assign acc_next    = acc_base + ACCW'(beat_sum_p2);
   assign bus.out_ovf = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_p3       <= '0;
         out_p_p3     <= '0;
         out_valid_p3 <= 1'b0;
      end else begin
         out_valid_p3 <= vld_p2 & last_p2;
         if (vld_p2) begin
            acc_p3 <= acc_next;
            if (last_p2) out_p_p3 <= acc_next;
         end
      end
   end

   assign bus.out_valid = out_valid_p3;
   assign bus.out_p     = out_p_p3;
endmodule

// File: tb/tb_dot_prod_acc.sv
// Directed bench for dot_prod_acc: default ACCW=32 instance plus an ACCW=20 instance for overflow.
module tb_dot_prod_acc;
   localparam int AW = 9;
   localparam int BW = 8;
   localparam int N  = 3;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   last_t;

   typedef struct {
      int     cyc;
      longint p;
      logic   ovf;
   } rec_t;

   rec_t q32[$];
   rec_t q20[$];

   dot_prod_acc_if #(.AW(AW), .BW(BW), .N(N), .ACCW(32)) bus32 ();
   dot_prod_acc_if #(.AW(AW), .BW(BW), .N(N), .ACCW(20)) bus20 ();

   dot_prod_acc #(.AW(AW), .BW(BW), .N(N), .ACCW(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
   dot_prod_acc #(.AW(AW), .BW(BW), .N(N), .ACCW(20)) dut20 (.clk(clk), .rst(rst), .bus(bus20.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus32.out_valid === 1'b1)
         q32.push_back('{cyc, longint'(bus32.out_p), bus32.out_ovf});
      if (bus20.out_valid === 1'b1)
         q20.push_back('{cyc, longint'(bus20.out_p), bus20.out_ovf});
   end

   task automatic beat(input logic f, input logic l, input logic n,
                       input int a0, input int a1, input int a2,
                       input int b0, input int b1, input int b2);
      bus32.in_valid = 1'b1; bus32.in_first = f; bus32.in_last = l; bus32.in_neg = n;
      bus20.in_valid = 1'b1; bus20.in_first = f; bus20.in_last = l; bus20.in_neg = n;
      bus32.a = {9'(a2), 9'(a1), 9'(a0)};
      bus20.a = {9'(a2), 9'(a1), 9'(a0)};
      bus32.b = {8'(b2), 8'(b1), 8'(b0)};
      bus20.b = {8'(b2), 8'(b1), 8'(b0)};
      last_t = cyc;
      @(posedge clk); #1;
      bus32.in_valid = 1'b0;
      bus20.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bus32.in_valid = 1'b0;
      bus20.in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic beat_big(input logic f, input logic l, input logic n);
      beat(f, l, n, -256, 255, 1, -128, 127, 0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(2);
      @(negedge clk);
      n_cmp++; if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus32.out_valid); end
      n_cmp++; if (bus32.out_p !== 32'sd0) begin n_err++; $display("FAIL reset_out_p got=%0d exp=0", bus32.out_p); end
      n_cmp++; if (bus32.out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf got=%b exp=0", bus32.out_ovf); end
      n_cmp++; if (bus20.out_p !== 20'sd0) begin n_err++; $display("FAIL reset_out_p20 got=%0d exp=0", bus20.out_p); end
      @(posedge clk); #1;
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_single(input logic neg, input longint exp_p);
      q32.delete(); q20.delete();
      beat_big(1'b1, 1'b1, neg);
      idle(5);
      n_cmp++;
      if (q32.size() != 1) begin
         n_err++; $display("FAIL single_count neg=%b got=%0d exp=1", neg, q32.size());
      end else begin
         n_cmp++; if (q32[0].cyc != last_t + 3) begin n_err++; $display("FAIL single_latency got=%0d exp=3", q32[0].cyc - last_t); end
         n_cmp++; if (q32[0].p != exp_p) begin n_err++; $display("FAIL single_out_p neg=%b got=%0d exp=%0d", neg, q32[0].p, exp_p); end
         n_cmp++; if (q32[0].ovf !== 1'b0) begin n_err++; $display("FAIL single_out_ovf got=%b exp=0", q32[0].ovf); end
      end
   endtask

   task automatic test_frame_bubbles;
      q32.delete(); q20.delete();
      beat(1'b1, 1'b0, 1'b0, 1, 2, 3, 4, 5, 6);
      beat(1'b0, 1'b0, 1'b0, 1, 2, 3, 4, 5, 6);
      idle(2);
      beat(1'b0, 1'b0, 1'b0, 1, 2, 3, 4, 5, 6);
      beat(1'b0, 1'b1, 1'b0, 1, 2, 3, 4, 5, 6);
      idle(5);
      n_cmp++;
      if (q32.size() != 1) begin
         n_err++; $display("FAIL frame_count got=%0d exp=1", q32.size());
      end else begin
         n_cmp++; if (q32[0].cyc != last_t + 3) begin n_err++; $display("FAIL frame_latency got=%0d exp=3", q32[0].cyc - last_t); end
         n_cmp++; if (q32[0].p != 128) begin n_err++; $display("FAIL frame_out_p got=%0d exp=128", q32[0].p); end
      end
   endtask

   task automatic test_back_to_back;
      longint exp_p [3];
      int     t0;
      exp_p = '{32, 65153, -1};
      q32.delete(); q20.delete();
      t0 = cyc;
      beat(1'b1, 1'b1, 1'b0, 1, 2, 3, 4, 5, 6);
      beat_big(1'b1, 1'b1, 1'b0);
      beat(1'b1, 1'b1, 1'b0, 1, 0, 0, -1, 0, 0);
      idle(5);
      n_cmp++;
      if (q32.size() != 3) begin
         n_err++; $display("FAIL b2b_count got=%0d exp=3", q32.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++; if (q32[i].p != exp_p[i]) begin n_err++; $display("FAIL b2b_out_p[%0d] got=%0d exp=%0d", i, q32[i].p, exp_p[i]); end
            n_cmp++; if (q32[i].cyc != t0 + 3 + i) begin n_err++; $display("FAIL b2b_cycle[%0d] got=%0d exp=%0d", i, q32[i].cyc, t0 + 3 + i); end
         end
      end
   endtask

   task automatic test_overflow;
`ifdef DOT_PROD_ACC_SAT_EN
      longint exp_p20 = 524287;
      logic   exp_ovf = 1'b1;
`else
      longint exp_p20 = -462199;
      logic   exp_ovf = 1'b0;
`endif
      q32.delete(); q20.delete();
      for (int i = 0; i < 9; i++)
         beat_big(i == 0, i == 8, 1'b0);
      idle(5);
      n_cmp++;
      if (q20.size() != 1 || q32.size() != 1) begin
         n_err++; $display("FAIL ovf_count got=%0d/%0d exp=1/1", q20.size(), q32.size());
      end else begin
         n_cmp++; if (q20[0].p != exp_p20) begin n_err++; $display("FAIL ovf_out_p20 got=%0d exp=%0d", q20[0].p, exp_p20); end
         n_cmp++; if (q20[0].ovf !== exp_ovf) begin n_err++; $display("FAIL ovf_flag20 got=%b exp=%b", q20[0].ovf, exp_ovf); end
         n_cmp++; if (q32[0].p != 586377) begin n_err++; $display("FAIL ovf_out_p32 got=%0d exp=586377", q32[0].p); end
      end
      q20.delete(); q32.delete();
      beat(1'b1, 1'b1, 1'b0, 1, 2, 3, 4, 5, 6);
      idle(5);
      n_cmp++;
      if (q20.size() != 1) begin
         n_err++; $display("FAIL ovf_next_count got=%0d exp=1", q20.size());
      end else begin
         n_cmp++; if (q20[0].p != 32) begin n_err++; $display("FAIL ovf_next_out_p got=%0d exp=32", q20[0].p); end
         n_cmp++; if (q20[0].ovf !== 1'b0) begin n_err++; $display("FAIL ovf_next_flag got=%b exp=0", q20[0].ovf); end
      end
   endtask

   task automatic test_reset_midframe;
      q32.delete(); q20.delete();
      beat(1'b1, 1'b0, 1'b0, 1, 2, 3, 4, 5, 6);
      beat(1'b0, 1'b0, 1'b0, 1, 2, 3, 4, 5, 6);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus32.out_p !== 32'sd0) begin n_err++; $display("FAIL midrst_out_p got=%0d exp=0", bus32.out_p); end
      @(posedge clk); #1;
      beat(1'b1, 1'b1, 1'b0, 1, 2, 3, 4, 5, 6);
      idle(5);
      n_cmp++;
      if (q32.size() != 1) begin
         n_err++; $display("FAIL midrst_count got=%0d exp=1", q32.size());
      end else begin
         n_cmp++; if (q32[0].p != 32) begin n_err++; $display("FAIL midrst_out_p_new got=%0d exp=32", q32[0].p); end
         n_cmp++; if (q32[0].cyc != last_t + 3) begin n_err++; $display("FAIL midrst_latency got=%0d exp=3", q32[0].cyc - last_t); end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus32.in_valid = 1'b0; bus32.in_first = 1'b0; bus32.in_last = 1'b0; bus32.in_neg = 1'b0;
      bus20.in_valid = 1'b0; bus20.in_first = 1'b0; bus20.in_last = 1'b0; bus20.in_neg = 1'b0;
      bus32.a = '0; bus32.b = '0; bus20.a = '0; bus20.b = '0;
      #1;
      test_reset();
      test_single(1'b0, 65153);
      test_single(1'b1, -65153);
      test_frame_bubbles();
      test_back_to_back();
      test_overflow();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
